// File: rtl/nco_ctrl_pkg.sv
// Shared types and default widths for the swept-source NCO controller.
package nco_ctrl_pkg;

    localparam int unsigned NCO_LAT = 4;

    localparam int unsigned DEF_APR = 32;
    localparam int unsigned DEF_NSW = 16;
    localparam int unsigned DEF_DWW = 16;
    localparam int unsigned DEF_LAT = NCO_LAT;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/nco_lat_pipe.sv
// Enabled shift register that delays sweep markers by the NCO latency.
module nco_lat_pipe #(
    parameter int unsigned W   = 2,
    parameter int unsigned LAT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    input  logic         flush_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [LAT];

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            for (int unsigned i = 0; i < LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int unsigned i = 1; i < LAT; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[LAT-1];

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding an NCO phase increment, with
// step/sweep markers delayed to line up with the NCO output samples.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
#(
    parameter int unsigned APR = DEF_APR,
    parameter int unsigned NSW = DEF_NSW,
    parameter int unsigned DWW = DEF_DWW,
    parameter int unsigned LAT = DEF_LAT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [APR-1:0] cfg_start_inc,
    input  logic [APR-1:0] cfg_step_inc,
    input  logic [NSW-1:0] cfg_nsteps,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic           start,
    input  logic           abort,
    input  logic           stall,
    output logic [APR-1:0] phi_inc_o,
    output logic           nco_clken_o,
    output logic           sweep_busy,
    output logic           sweep_done,
    output logic [NSW-1:0] step_idx_o,
    output logic           sweep_sync_o,
    output logic           step_sync_o
);

    localparam int unsigned     DCW        = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [DCW-1:0]  DRAIN_LAST = DCW'(LAT - 1);

    state_e         state_q,       state_d;
    logic [APR-1:0] phi_q,         phi_d;
    logic [APR-1:0] step_inc_q,    step_inc_d;
    logic [NSW-1:0] nsteps_q,      nsteps_d;
    logic [NSW-1:0] idx_q,         idx_d;
    logic [DWW-1:0] dwell_q,       dwell_d;
    logic [DWW-1:0] dwell_cnt_q,   dwell_cnt_d;
    logic [DCW-1:0] drain_cnt_q,   drain_cnt_d;
    logic           busy_q,        busy_d;
    logic           done_q,        done_d;
    logic           step_first_q,  step_first_d;
    logic           sweep_first_q, sweep_first_d;
    logic [1:0]     sync_pipe;
    logic           en;

    assign en = ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            phi_q         <= '0;
            step_inc_q    <= '0;
            nsteps_q      <= '0;
            idx_q         <= '0;
            dwell_q       <= '0;
            dwell_cnt_q   <= '0;
            drain_cnt_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            step_first_q  <= 1'b0;
            sweep_first_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phi_q         <= phi_d;
            step_inc_q    <= step_inc_d;
            nsteps_q      <= nsteps_d;
            idx_q         <= idx_d;
            dwell_q       <= dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            step_first_q  <= step_first_d;
            sweep_first_q <= sweep_first_d;
        end
    end

    // Sweep sequencing; abort overrides stall, otherwise nothing moves while stalled.
    always_comb begin
        state_d       = state_q;
        phi_d         = phi_q;
        step_inc_d    = step_inc_q;
        nsteps_d      = nsteps_q;
        idx_d         = idx_q;
        dwell_d       = dwell_q;
        dwell_cnt_d   = dwell_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        busy_d        = busy_q;
        done_d        = done_q;
        step_first_d  = step_first_q;
        sweep_first_d = sweep_first_q;

        if (abort) begin
            state_d       = ST_IDLE;
            busy_d        = 1'b0;
            done_d        = 1'b0;
            step_first_d  = 1'b0;
            sweep_first_d = 1'b0;
        end else if (en) begin
            done_d        = 1'b0;
            step_first_d  = 1'b0;
            sweep_first_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d       = ST_RUN;
                        phi_d         = cfg_start_inc;
                        step_inc_d    = cfg_step_inc;
                        nsteps_d      = cfg_nsteps;
                        dwell_d       = cfg_dwell;
                        idx_d         = '0;
                        dwell_cnt_d   = '0;
                        busy_d        = 1'b1;
                        step_first_d  = 1'b1;
                        sweep_first_d = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (dwell_cnt_q != dwell_q) begin
                        dwell_cnt_d = dwell_cnt_q + DWW'(1);
                    end else if (idx_q != nsteps_q) begin
                        phi_d        = phi_q + step_inc_q;
                        idx_d        = idx_q + NSW'(1);
                        dwell_cnt_d  = '0;
                        step_first_d = 1'b1;
                    end else begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = '0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        drain_cnt_d = drain_cnt_q + DCW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    nco_lat_pipe #(
        .W   (2),
        .LAT (LAT)
    ) u_lat_pipe (
        .clk     (clk),
        .reset   (reset),
        .en_i    (en),
        .flush_i (abort),
        .d_i     ({sweep_first_q, step_first_q}),
        .q_o     (sync_pipe)
    );

    assign phi_inc_o    = phi_q;
    assign step_idx_o   = idx_q;
    assign sweep_busy   = busy_q;
    assign sweep_done   = done_q;
    assign sweep_sync_o = sync_pipe[1];
    assign step_sync_o  = sync_pipe[0];
    assign nco_clken_o  = ~stall & ~reset;

endmodule
